// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer feeding the per-instruction IW decoders.
// Latches the instruction word into I, owns the 2-bit micro-state, the status
// register and the micro-step watchdog, and gates the decoder's control word
// onto the datapath.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   instr_in/_valid    instruction word and its valid strobe
//   instr_req          fetch request (combinational, FETCH only)
//   halt               stop at the next instruction boundary (sampled in FETCH)
//   status_in          ALU flags, loaded when control word status_ld=1
//   cw_in              control word from the selected decoder
//   I, state, status   instruction register, micro-state, status to decoders
//   cw_out             gated control word to datapath (combinational)
//   retire             completion pulse (combinational)
//   uop_err            sticky watchdog error
//   halted             sequencer idle in HALT
//
// Optional feature macro SEQ_PERF_CNT_EN adds perf_retired / perf_cycles counters.
module control_sequencer #(
    parameter int unsigned CW_W       = 33,
    parameter int unsigned STATUS_W   = 5,
    parameter int unsigned MAX_USTEPS = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [31:0]         instr_in,
    input  logic                instr_valid,
    output logic                instr_req,
    input  logic                halt,
    input  logic [STATUS_W-1:0] status_in,
    input  logic [CW_W-1:0]     cw_in,
    output logic [31:0]         I,
    output logic [1:0]          state,
    output logic [STATUS_W-1:0] status,
    output logic [CW_W-1:0]     cw_out,
    output logic                retire,
    output logic                uop_err,
    output logic                halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_retired,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int unsigned STEP_W = (MAX_USTEPS > 1) ? $clog2(MAX_USTEPS) : 1;

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_HALT  = 2'd2
    } phase_e;

    phase_e                phase_q, phase_d;
    logic [31:0]           i_q, i_d;
    logic [1:0]            state_q, state_d;
    logic [STATUS_W-1:0]   status_q, status_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  uop_err_q, uop_err_d;
    logic                  watchdog_c;
    logic [1:0]            next_st_c;

    assign next_st_c  = cw_in[1:0];
    // Last allowed step still asks for another micro-state: abort the instruction.
    assign watchdog_c = (phase_q == PH_EXEC) &&
                        (step_q == STEP_W'(MAX_USTEPS - 1)) &&
                        (next_st_c != 2'b00);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_FETCH;
            i_q       <= '0;
            state_q   <= 2'b00;
            status_q  <= '0;
            step_q    <= '0;
            uop_err_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            i_q       <= i_d;
            state_q   <= state_d;
            status_q  <= status_d;
            step_q    <= step_d;
            uop_err_q <= uop_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        phase_d   = phase_q;
        i_d       = i_q;
        state_d   = state_q;
        status_d  = status_q;
        step_d    = step_q;
        uop_err_d = uop_err_q;
        case (phase_q)
            PH_FETCH: begin
                // halt wins over a simultaneous instruction arrival
                if (halt) begin
                    phase_d = PH_HALT;
                end else if (instr_valid) begin
                    i_d     = instr_in;
                    state_d = 2'b00;
                    step_d  = '0;
                    phase_d = PH_EXEC;
                end
            end
            PH_EXEC: begin
                if (watchdog_c) begin
                    // Aborted step is fully suppressed, including the status load
                    uop_err_d = 1'b1;
                    state_d   = 2'b00;
                    phase_d   = PH_FETCH;
                end else begin
                    state_d = next_st_c;
                    step_d  = step_q + STEP_W'(1);
                    if (cw_in[2]) begin
                        status_d = status_in;
                    end
                    if (next_st_c == 2'b00) begin
                        phase_d = PH_FETCH;
                    end
                end
            end
            PH_HALT: begin
                if (!halt) begin
                    phase_d = PH_FETCH;
                end
            end
            default: phase_d = PH_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        instr_req = 1'b0;
        cw_out    = '0;
        retire    = 1'b0;
        case (phase_q)
            PH_FETCH: instr_req = reset_n & ~halt;
            PH_EXEC: begin
                if (!watchdog_c) begin
                    cw_out = cw_in;
                    retire = (next_st_c == 2'b00);
                end
            end
            default: ;
        endcase
    end

    assign I       = i_q;
    assign state   = state_q;
    assign status  = status_q;
    assign uop_err = uop_err_q;
    assign halted  = (phase_q == PH_HALT);

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;

    // Retire and non-HALT cycle counters, free-running modulo 2^32
    always_comb begin
        perf_retired_d = perf_retired_q + 32'(retire);
        perf_cycles_d  = perf_cycles_q + 32'(phase_q != PH_HALT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_retired_q <= '0;
            perf_cycles_q  <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_cycles_q  <= perf_cycles_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_cycles  = perf_cycles_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer. Each driven cycle
// pushes its expected outputs; they are popped and compared once the cycle's
// combinational outputs and post-edge registers have been sampled.
module tb_control_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_req;
    logic        halt;
    logic [4:0]  status_in;
    logic [32:0] cw_in;
    logic [31:0] I;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] cw_out;
    logic        retire;
    logic        uop_err;
    logic        halted;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_cycles;
`endif

    control_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .halt        (halt),
        .status_in   (status_in),
        .cw_in       (cw_in),
        .I           (I),
        .state       (state),
        .status      (status),
        .cw_out      (cw_out),
        .retire      (retire),
        .uop_err     (uop_err),
        .halted      (halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_retired(perf_retired),
        .perf_cycles (perf_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        req;
        logic        ret;
        logic [32:0] cw;
        logic [1:0]  st;
        logic [4:0]  stat;
        logic        err;
        logic        hlt;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] IA  = 32'hF2A0_0123;
    localparam logic [31:0] IB  = 32'h1111_2222;
    localparam logic [31:0] IC  = 32'hDEAD_BEEF;
    localparam logic [31:0] ID  = 32'h3333_3333;
    localparam logic [31:0] IE  = 32'h4444_4444;
    localparam logic [31:0] IF  = 32'h5555_5555;
    localparam logic [32:0] CW1 = 33'h1_2345_6778; // next 00
    localparam logic [32:0] CW2 = 33'h0_ABCD_0011; // next 01
    localparam logic [32:0] CW3 = 33'h1_0000_F0F0; // next 00
    localparam logic [32:0] CWS = 33'h0_0000_0005; // status_ld, next 01
    localparam logic [32:0] CWH = 33'h1_8000_0000; // next 00, no load
    localparam logic [32:0] CWW = 33'h0_5555_5551; // next 01 forever
    localparam logic [4:0]  S   = 5'b10101;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic req, input logic ret, input logic [32:0] cw,
                                input logic [1:0] st, input logic [4:0] stat,
                                input logic err, input logic hlt, input logic [31:0] ir);
        exp_t e;
        e.req = req; e.ret = ret; e.cw = cw; e.st = st;
        e.stat = stat; e.err = err; e.hlt = hlt; e.ir = ir;
        return e;
    endfunction

    // Drive one cycle, push its expectation, sample, then pop and compare.
    task automatic step(input string name, input logic v, input logic [31:0] ins,
                        input logic h, input logic [4:0] si, input logic [32:0] cw,
                        input exp_t e);
        exp_t        x;
        logic        o_req;
        logic        o_ret;
        logic [32:0] o_cw;
        @(negedge clock);
        instr_valid = v;
        instr_in    = ins;
        halt        = h;
        status_in   = si;
        cw_in       = cw;
        sb.push_back(e);
        #1;
        o_req = instr_req;
        o_ret = retire;
        o_cw  = cw_out;
        @(posedge clock);
        #1;
        x = sb.pop_front();
        chk({name, ".instr_req"}, 64'(o_req),   64'(x.req));
        chk({name, ".retire"},    64'(o_ret),   64'(x.ret));
        chk({name, ".cw_out"},    64'(o_cw),    64'(x.cw));
        chk({name, ".state"},     64'(state),   64'(x.st));
        chk({name, ".status"},    64'(status),  64'(x.stat));
        chk({name, ".uop_err"},   64'(uop_err), 64'(x.err));
        chk({name, ".halted"},    64'(halted),  64'(x.hlt));
        chk({name, ".I"},         64'(I),       64'(x.ir));
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_in    = '0;
        instr_valid = 1'b0;
        halt        = 1'b0;
        status_in   = '0;
        cw_in       = CW1;
        #12;
        chk("rst.I",         64'(I),         64'd0);
        chk("rst.state",     64'(state),     64'd0);
        chk("rst.status",    64'(status),    64'd0);
        chk("rst.cw_out",    64'(cw_out),    64'd0);
        chk("rst.retire",    64'(retire),    64'd0);
        chk("rst.instr_req", 64'(instr_req), 64'd0);
        chk("rst.uop_err",   64'(uop_err),   64'd0);
        chk("rst.halted",    64'(halted),    64'd0);
        #1 reset_n = 1'b1;

        step("idle",  0, 32'h0, 0, 5'd0, CW1, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, 32'h0));

        // Single-step instruction
        step("s1_f",  1, IA,    0, 5'd0, CW1, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, IA));
        step("s1_e",  0, 32'h0, 0, 5'd0, CW1, mk(0, 1, CW1,   2'd0, 5'd0, 0, 0, IA));
        step("s1_n",  0, 32'h0, 0, 5'd0, CW1, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, IA));

        // Two-step instruction; instr_valid during EXEC must be ignored
        step("t2_f",  1, IB,    0, 5'd0, CW2, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, IB));
        step("t2_e0", 1, IC,    0, 5'd0, CW2, mk(0, 0, CW2,   2'd1, 5'd0, 0, 0, IB));
        step("t2_e1", 1, IC,    0, 5'd0, CW3, mk(0, 1, CW3,   2'd0, 5'd0, 0, 0, IB));

        // Status load then hold
        step("st_f",  1, ID,    0, 5'd0, CWS, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, ID));
        step("st_e0", 0, 32'h0, 0, S,    CWS, mk(0, 0, CWS,   2'd1, S,    0, 0, ID));
        step("st_e1", 0, 32'h0, 0, 5'd0, CWH, mk(0, 1, CWH,   2'd0, S,    0, 0, ID));

        // Watchdog abort on the fourth step
        step("wd_f",  1, IE,    0, 5'd0, CWW, mk(1, 0, 33'h0, 2'd0, S,    0, 0, IE));
        for (int k = 0; k < 3; k++)
            step($sformatf("wd_e%0d", k), 0, 32'h0, 0, 5'd0, CWW,
                 mk(0, 0, CWW, 2'd1, S, 0, 0, IE));
        step("wd_e3", 0, 32'h0, 0, 5'd0, CWW, mk(0, 0, 33'h0, 2'd0, S,    1, 0, IE));
        step("wd_n",  0, 32'h0, 0, 5'd0, CWW, mk(1, 0, 33'h0, 2'd0, S,    1, 0, IE));

        // Halt raised mid-EXEC takes effect only at the boundary
        step("h_f",   1, IF,    0, 5'd0, CW2, mk(1, 0, 33'h0, 2'd0, S,    1, 0, IF));
        step("h_e0",  0, 32'h0, 1, 5'd0, CW2, mk(0, 0, CW2,   2'd1, S,    1, 0, IF));
        step("h_e1",  0, 32'h0, 1, 5'd0, CW3, mk(0, 1, CW3,   2'd0, S,    1, 0, IF));
        step("h_fh",  1, IA,    1, 5'd0, CW1, mk(0, 0, 33'h0, 2'd0, S,    1, 1, IF));
        step("h_hh",  1, IA,    1, 5'd0, CW1, mk(0, 0, 33'h0, 2'd0, S,    1, 1, IF));
        step("h_rel", 1, IA,    0, 5'd0, CW1, mk(0, 0, 33'h0, 2'd0, S,    1, 0, IF));
        step("h_go",  0, 32'h0, 0, 5'd0, CW1, mk(1, 0, 33'h0, 2'd0, S,    1, 0, IF));

        // Reset asserted mid-EXEC aborts without a retire
        step("r_f",   1, IA,    0, 5'd0, CW2, mk(1, 0, 33'h0, 2'd0, S,    1, 0, IA));
        @(negedge clock);
        instr_valid = 1'b0;
        cw_in       = CW1;
        #1;
        chk("r_pre.retire", 64'(retire), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("r_mid.state",     64'(state),     64'd0);
        chk("r_mid.cw_out",    64'(cw_out),    64'd0);
        chk("r_mid.retire",    64'(retire),    64'd0);
        chk("r_mid.uop_err",   64'(uop_err),   64'd0);
        chk("r_mid.status",    64'(status),    64'd0);
        chk("r_mid.I",         64'(I),         64'd0);
        chk("r_mid.instr_req", 64'(instr_req), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step("r_post", 0, 32'h0, 0, 5'd0, CW1, mk(1, 0, 33'h0, 2'd0, 5'd0, 0, 0, 32'h0));

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control-unit sequencer directly upstream of the per-instruction IW decoders.
- Fetches the 32-bit instruction word and holds it in the instruction register (I).
- Owns the 2-bit micro-state and the 5-bit status register, and presents I, state and status to the decoders.
- Takes back the selected 33-bit control word, gates it onto the datapath, and advances the micro-state from the control word's next_state field until the instruction retires.

Parameters:
- CW_W, 33: control word width.
- STATUS_W, 5: status register width.
- MAX_USTEPS, 4: maximum micro-steps per instruction before watchdog abort.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_in  in  32  instruction word from instruction memory.
- instr_valid  in  1  instr_in valid this cycle.
- instr_req  out  1  fetch request to instruction memory.
- halt  in  1  stop at the next instruction boundary.
- status_in  in  STATUS_W  ALU flags.
- cw_in  in  CW_W  control word from the selected decoder.
- I  out  32  instruction register, to decoders.
- state  out  2  micro-state, to decoders.
- status  out  STATUS_W  status register, to decoders.
- cw_out  out  CW_W  gated control word, to datapath.
- retire  out  1  one-cycle pulse when an instruction completes.
- uop_err  out  1  sticky watchdog error.
- halted  out  1  sequencer idle in HALT.

Behaviour:
- Control word layout (MSB to LSB):
  - [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en
  - [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da
  - [9] rf_w, [8] ram_en, [7] ram_w, [6] pc_en, [5:4] pc_fs, [3] pc_is
  - [2] status_ld, [1:0] next_state
- Phase FSM: FETCH, EXEC, HALT.
- Reset (asynchronous, reset_n=0):
  - phase=FETCH; I=0; state=00; status=0; step count=0.
  - retire=0; uop_err=0; halted=0; instr_req=0 for the reset cycle.
- FETCH:
  - instr_req=1 combinationally; cw_out=0, so no register/RAM write and pc_fs=00.
  - If halt=1 on entry cycle: go to HALT, do not request.
  - On the rising edge with instr_valid=1: I<=instr_in, state<=00, step count<=0, phase<=EXEC.
  - instr_valid while not in FETCH is ignored.
- EXEC:
  - instr_req=0; cw_out=cw_in, passed through combinationally.
  - Each edge: state<=cw_in[1:0]; step count+1.
  - If cw_in[2]=1: status<=status_in the same edge. Otherwise status holds.
  - If cw_in[1:0]==00: retire=1 during this cycle (combinational); phase<=FETCH next edge.
  - Single-step instructions take 1 EXEC cycle. A two-step instruction (00 then 01 then back to 00) takes 2.
  - Watchdog: if step count==MAX_USTEPS-1 and cw_in[1:0]!=00:
    - uop_err<=1 (sticky until reset), state<=00, phase<=FETCH.
    - cw_out is forced to 0 in that cycle.
    - No retire pulse.
- HALT:
  - halted=1, cw_out=0, instr_req=0.
  - When halt=0: phase<=FETCH.
  - halt is sampled only in FETCH; halt asserted mid-EXEC has no effect until the instruction retires.
- Minimum throughput: 1 fetch cycle + N exec cycles per instruction, with back-to-back instr_valid.
- reset_n asserted mid-EXEC aborts immediately: state=00, cw_out=0 on the next evaluation, no retire.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds output perf_retired (32 bits) counting retire pulses, and output perf_cycles (32 bits) counting every non-HALT cycle.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: no counters and no ports; behaviour otherwise identical.

Test Plan:
- Reset: hold reset_n=0 → I=0, state=00, status=0, cw_out=0, retire=0. Release with instr_valid=0 → instr_req=1, cw_out stays 0.
- Single-step instruction: instr_in=32'hF2A0_0123, valid 1 cycle; cw_in next_state=00 → one EXEC cycle, retire pulse, cw_out==cw_in in that cycle, instr_req=1 on the next cycle.
- Two-step instruction: cw_in next_state=01 in state 00, then 00 in state 01 → state goes 00→01→00, exactly one retire on the second EXEC cycle.
- Status load: status_in=5'b10101 with cw_in[2]=1 → status=5'b10101 after the edge. Then status_in=0 with cw_in[2]=0 → status holds 10101.
- Watchdog: cw_in next_state always 01 → after 4 EXEC cycles uop_err=1, no retire, phase returns to FETCH, uop_err stays 1.
- Halt: assert halt in mid-EXEC → the instruction completes, then halted=1 and instr_req=0. Deassert halt → the next cycle has instr_req=1.
